// File: rtl/mult_hilo_sequencer.sv
// Multi-cycle radix-2 shift-add multiplier that owns the HI/LO pair and stalls stale mfhi/mflo reads.
// Define MULT_SIGNED_EN for signed mult semantics; the default build implements unsigned multu.
//   state | meaning
//   IDLE  | nothing in flight, hi/lo valid
//   RUN   | shift-add iterations in progress
//   DONE  | hi/lo written on entry, done pulses this cycle
module mult_hilo_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             kill,
  input  logic             mf_req,
  input  logic             hi_sel,
  output logic [WIDTH-1:0] hilo_out,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   hi, lo, mcand, mag_a, mag_b;
  logic [2*WIDTH-1:0] acc, acc_nxt, prod;
  logic [WIDTH:0]     sum;
  logic [CNT_W-1:0]   cnt;
  logic               last;

`ifdef MULT_SIGNED_EN
  logic neg;
  assign mag_a = op_a[WIDTH-1] ? (~op_a + WIDTH'(1)) : op_a;
  assign mag_b = op_b[WIDTH-1] ? (~op_b + WIDTH'(1)) : op_b;
  assign prod  = neg ? (~acc_nxt + (2*WIDTH)'(1)) : acc_nxt;
`else
  assign mag_a = op_a;
  assign mag_b = op_b;
  assign prod  = acc_nxt;
`endif

  // Upper half plus carry accumulates; lower half starts as the multiplier and drains out.
  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    acc_nxt = {sum, acc[WIDTH-1:1]};
  end

  assign last = (cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = start ? RUN : IDLE;
      RUN: begin
        if (kill)      state_nxt = IDLE;
        else if (last) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi    <= '0;
      lo    <= '0;
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
`ifdef MULT_SIGNED_EN
      neg   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mcand <= mag_a;
            acc   <= {{WIDTH{1'b0}}, mag_b};
            cnt   <= CNT_INIT;
`ifdef MULT_SIGNED_EN
            neg   <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          if (!kill) begin
            acc <= acc_nxt;
            cnt <= cnt - CNT_W'(1);
            if (last) {hi, lo} <= prod;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state == RUN);
  assign done     = (state == DONE);
  assign stall    = mf_req & (busy | start);
  assign hilo_out = hi_sel ? hi : lo;

endmodule

// File: tb/tb_mult_hilo_sequencer.sv
// Directed self-checking bench for mult_hilo_sequencer; expectations follow MULT_SIGNED_EN.
module tb_mult_hilo_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, kill, mf_req, hi_sel;
  logic [W-1:0] op_a, op_b, hilo_out;
  logic         busy, done, stall;

  int tests = 0;
  int fails = 0;

  mult_hilo_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .kill(kill), .mf_req(mf_req), .hi_sel(hi_sel), .hilo_out(hilo_out),
    .busy(busy), .done(done), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reads hi/lo through the mux; leaves hi_sel at 0.
  task automatic read_hilo(output logic [W-1:0] h, output logic [W-1:0] l);
    hi_sel = 1'b1; #1; h = hilo_out;
    hi_sel = 1'b0; #1; l = hilo_out;
  endtask

  task automatic test_reset();
    logic [W-1:0] h, l;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    read_hilo(h, l);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0 || h !== '0 || l !== '0) begin
      fails++;
      $display("FAIL reset: busy=%b done=%b stall=%b hi=%h lo=%h, required 0 0 0 0 0", busy, done, stall, h, l);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] h, l;
    start = 1'b1; op_a = 6; op_b = 7;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      tests++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        fails++;
        $display("FAIL basic_busy cycle %0d: busy=%b done=%b, required 1 0", c, busy, done);
      end
      tick();
    end
    read_hilo(h, l);
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || h !== 32'd0 || l !== 32'd42) begin
      fails++;
      $display("FAIL basic_done: done=%b busy=%b hi=%h lo=%h, required 1 0 0 2a", done, busy, h, l);
    end
    tick();
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL basic_pulse: done=%b on cycle 34, required 0", done);
    end
  endtask

  task automatic test_products();
    logic [W-1:0] va [5], vb [5], eh [5], el [5];
    logic [W-1:0] h, l;
    va[0] = 32'hFFFF_FFFF; vb[0] = 32'hFFFF_FFFF;
    va[1] = 32'hFFFF_FFFD; vb[1] = 32'd5;
    va[2] = 32'h8000_0000; vb[2] = 32'h8000_0000;
    va[3] = 32'h0001_0000; vb[3] = 32'h0001_0000;
    va[4] = 32'hFFFF_FFFF; vb[4] = 32'd2;
`ifdef MULT_SIGNED_EN
    eh[0] = 32'h0000_0000; el[0] = 32'h0000_0001;
    eh[1] = 32'hFFFF_FFFF; el[1] = 32'hFFFF_FFF1;
    eh[4] = 32'hFFFF_FFFF; el[4] = 32'hFFFF_FFFE;
`else
    eh[0] = 32'hFFFF_FFFE; el[0] = 32'h0000_0001;
    eh[1] = 32'h0000_0004; el[1] = 32'hFFFF_FFF1;
    eh[4] = 32'h0000_0001; el[4] = 32'hFFFF_FFFE;
`endif
    eh[2] = 32'h4000_0000; el[2] = 32'h0000_0000;
    eh[3] = 32'h0000_0001; el[3] = 32'h0000_0000;
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; op_a = va[i]; op_b = vb[i];
      tick();
      start = 1'b0;
      for (int c = 1; c <= 32; c++) tick();
      read_hilo(h, l);
      tests++;
      if (done !== 1'b1 || h !== eh[i] || l !== el[i]) begin
        fails++;
        $display("FAIL product %h*%h: done=%b hi=%h lo=%h, required 1 %h %h", va[i], vb[i], done, h, l, eh[i], el[i]);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    start = 1'b1; op_a = 9; op_b = 11;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      if (c == 5) begin mf_req = 1'b1; hi_sel = 1'b0; #1; end
      tests++;
      if (stall !== (c >= 5)) begin
        fails++;
        $display("FAIL stall cycle %0d: stall=%b, required %b", c, stall, (c >= 5));
      end
      tick();
    end
    tests++;
    if (stall !== 1'b0 || done !== 1'b1 || hilo_out !== 32'd99) begin
      fails++;
      $display("FAIL stall_release: stall=%b done=%b hilo_out=%h, required 0 1 63", stall, done, hilo_out);
    end
    mf_req = 1'b0;
    tick();
  endtask

  task automatic test_kill();
    logic [W-1:0] h, l;
    int saw_done;
    start = 1'b1; op_a = 32'h1234; op_b = 32'h10; mf_req = 1'b1;
    #1;
    tests++;
    if (stall !== 1'b1) begin
      fails++;
      $display("FAIL start_stall: stall=%b, required 1", stall);
    end
    tick();
    start = 1'b0; mf_req = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL kill_idle: busy=%b done=%b, required 0 0", busy, done);
    end
    saw_done = 0;
    for (int c = 0; c < 30; c++) begin
      if (done === 1'b1) saw_done++;
      tick();
    end
    read_hilo(h, l);
    tests++;
    if (saw_done != 0 || h !== 32'd0 || l !== 32'd99) begin
      fails++;
      $display("FAIL kill_hold: done_pulses=%0d hi=%h lo=%h, required 0 0 63", saw_done, h, l);
    end
    // kill in IDLE must not block a start
    start = 1'b1; kill = 1'b1; op_a = 3; op_b = 3;
    tick();
    start = 1'b0; kill = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL kill_outside_run: busy=%b, required 1", busy);
    end
    for (int c = 1; c <= 32; c++) tick();
    read_hilo(h, l);
    tests++;
    if (done !== 1'b1 || l !== 32'd9) begin
      fails++;
      $display("FAIL kill_outside_result: done=%b lo=%h, required 1 9", done, l);
    end
    tick();
  endtask

  task automatic test_ignored_start();
    logic [W-1:0] h, l;
    start = 1'b1; op_a = 6; op_b = 7;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      if (c == 10) begin start = 1'b1; op_a = 100; op_b = 100; end
      if (c == 11) start = 1'b0;
      tick();
    end
    read_hilo(h, l);
    tests++;
    if (done !== 1'b1 || h !== 32'd0 || l !== 32'd42) begin
      fails++;
      $display("FAIL ignored_start: done=%b hi=%h lo=%h, required 1 0 2a", done, h, l);
    end
    tick();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL ignored_start_rerun: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] h, l;
    start = 1'b1; op_a = 5; op_b = 5;
    tick();
    start = 1'b0;
    for (int c = 1; c < 15; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    read_hilo(h, l);
    tests++;
    if (h !== '0 || l !== '0 || busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: hi=%h lo=%h busy=%b done=%b stall=%b, required all 0", h, l, busy, done, stall);
    end
    for (int c = 0; c < 40; c++) tick();
    read_hilo(h, l);
    tests++;
    if (l !== '0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_discard: lo=%h done=%b, required 0 0", l, done);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] h, l;
    start = 1'b1; op_a = 2; op_b = 3;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 32; c++) tick();
    read_hilo(h, l);
    tests++;
    if (done !== 1'b1 || l !== 32'd6) begin
      fails++;
      $display("FAIL b2b_first: done=%b lo=%h, required 1 6", done, l);
    end
    start = 1'b1; op_a = 4; op_b = 5;
    tick();
    start = 1'b0;
    tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL b2b_restart: busy=%b done=%b, required 1 0", busy, done);
    end
    for (int c = 0; c < 31; c++) tick();
    tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL b2b_running: busy=%b done=%b at cycle 65, required 1 0", busy, done);
    end
    tick();
    read_hilo(h, l);
    tests++;
    if (done !== 1'b1 || h !== 32'd0 || l !== 32'd20) begin
      fails++;
      $display("FAIL b2b_second: done=%b hi=%h lo=%h, required 1 0 14", done, h, l);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; kill = 1'b0; mf_req = 1'b0; hi_sel = 1'b0;
    op_a = '0; op_b = '0;
    test_reset();
    test_basic();
    test_products();
    test_stall();
    test_kill();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
